cordic_result_collector: RTL and testbench
==========================================

Name: cordic_result_collector

Overview:
Receiving end of the CORDIC output interface. Takes the valid-only st_cordic_out stream, narrows each 18-bit x/y/z field back to the 16-bit cordic_data_in format with optional rounding and saturation, and buffers results in a FIFO. The buffered results are presented downstream with a valid/ready handshake. The CORDIC pipeline cannot stall, so the block also runs a credit counter that tells the issuing side when a new request may enter the pipeline.

Parameters:
DEPTH, 8, FIFO entries and initial credit count; power of two, at least 2.
FRAC_SHIFT, 2, right shift applied when narrowing 18-bit to 16-bit; legal range 0..4.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cordic_out_i  input  55  st_cordic_out {vld, data.x, data.y, data.z}
issue_i  input  1  upstream launched one request into the CORDIC this cycle
credit_avail_o  output  1  at least one credit free; issuing is permitted
res_vld_o  output  1  FIFO head valid
res_rdy_i  input  1  downstream accepts the head
res_data_o  output  48  cordic_data_in {x, y, z} at the FIFO head
res_sat_o  output  3  per-field saturation flags of the head {x, y, z}
fill_o  output  $clog2(DEPTH+1)  current FIFO occupancy
err_o  output  1  sticky protocol error: overflow or issue without credit

Behaviour:
- Reset values: res_vld_o=0, res_data_o=0, res_sat_o=0, fill_o=0, err_o=0, credit counter=DEPTH, credit_avail_o=1. Reset mid-operation discards FIFO contents and in-flight accounting in the same cycle.
- Narrowing, per field, combinational on push:
  - Form v = field + (ROUND_EN ? 2^(FRAC_SHIFT-1) : 0) in 19-bit signed, then arithmetic right shift by FRAC_SHIFT.
  - When FRAC_SHIFT=0, no rounding term is added.
  - If v > 32767, store 32767 and set the sat bit. If v < -32768, store -32768 and set the sat bit. Otherwise store v[15:0] and clear the sat bit.
- Push: cordic_out_i.vld=1 writes {narrowed data, sat} at the write pointer.
- Pop: res_vld_o && res_rdy_i advances the read pointer.
- Pointers use an extra wrap bit; full and empty are distinguished by that wrap bit.
- Latency: push in cycle N makes the data visible at the head in cycle N+1. There is no fall-through, so res_vld_o stays low in the push cycle of an empty FIFO.
- Head stability: res_data_o and res_sat_o hold steady while res_vld_o=1 and res_rdy_i=0.
- Full FIFO with push and pop in the same cycle: both take effect and occupancy is unchanged.
- Full FIFO with push and no pop: the data is dropped, occupancy is unchanged, and err_o is set.
- Credit counter (0..DEPTH):
  - Decrement on issue_i.
  - Increment on pop.
  - Both in the same cycle: unchanged.
  - credit_avail_o = (counter != 0), registered value.
- issue_i while the counter is 0: the counter stays 0 and err_o is set.
- err_o clears only on rst.
- fill_o is the registered occupancy.

Optional Feature:
Macro CORDIC_RES_ROUND_EN.
- Defined: round-half-up as above; the +2^(FRAC_SHIFT-1) term can cause positive saturation.
- Undefined: the rounding term is 0 (pure truncation toward minus infinity); with FRAC_SHIFT>=2 the sat flags can never assert.

Test Plan:
- Single result, x=1000, y=-1000, z=1002, FRAC_SHIFT=2, ROUND_EN defined -> one cycle later res_vld_o=1 with x=250, y=-250, z=251, sat=000.
- Same stimulus with ROUND_EN undefined -> x=250, y=-250, z=250.
- Saturation: x=131071 (18'h1FFFF), y=-131072, ROUND_EN defined -> x=32767 with sat[x]=1; y=-32768 with sat[y]=0. With FRAC_SHIFT=1: x -> 32767 with sat=1, y -> -32768 with sat=1.
- Credits, DEPTH=8:
  - Assert issue_i for 8 cycles with res_rdy_i=0 -> credit_avail_o=0 from cycle 9.
  - One pop -> credit_avail_o=1 next cycle.
  - A 9th issue_i while at 0 credits -> err_o=1 and the counter stays 0.
- Overflow: 8 pushes with res_rdy_i=0 -> fill_o=8. A 9th push alone -> data dropped, err_o=1, fill_o=8. A 9th push together with a pop -> accepted, fill_o=8, err_o unchanged.
- Back-pressure and reset:
  - Toggle res_rdy_i randomly over 32 pushes -> all results popped in order with the head stable while stalled.
  - Assert rst with fill_o=5 -> next cycle fill_o=0, res_vld_o=0, credit_avail_o=1.

Source files
------------

// File: rtl/cordic_result_collector.sv
// cordic_result_collector
// Receives the valid-only CORDIC output stream and narrows each 18-bit field
// to 16 bits, with optional rounding and with saturation. Results are held
// in a FIFO and offered downstream over valid/ready. A credit counter tells
// the issuing side when another request may enter the non-stalling pipeline.
//
// Build option: define CORDIC_RES_ROUND_EN to add a round-half-up term before
// the shift. Without it the shift truncates toward minus infinity.
module cordic_result_collector #(
    parameter int DEPTH      = 8,
    parameter int FRAC_SHIFT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [54:0]                cordic_out_i,
    input  logic                       issue_i,
    output logic                       credit_avail_o,
    output logic                       res_vld_o,
    input  logic                       res_rdy_i,
    output logic [47:0]                res_data_o,
    output logic [2:0]                 res_sat_o,
    output logic [$clog2(DEPTH+1)-1:0] fill_o,
    output logic                       err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH+1);

`ifdef CORDIC_RES_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    // Half an output LSB; evaluates to 0 when FRAC_SHIFT is 0.
    localparam int                RND_INT = ROUND_EN ? (2**FRAC_SHIFT) / 2 : 0;
    localparam logic signed [18:0] RND    = 19'(RND_INT);
    localparam logic signed [18:0] V_MAX  = 19'sd32767;
    localparam logic signed [18:0] V_MIN  = -19'sd32768;

    typedef struct packed {
        logic [47:0] data;
        logic [2:0]  sat;
    } entry_t;

    // Returns {sat, value16} for one 18-bit signed field.
    function automatic logic [16:0] narrow_field(input logic [17:0] f);
        logic signed [18:0] v;
        v = $signed({f[17], f}) + RND;
        v = v >>> FRAC_SHIFT;
        if (v > V_MAX) begin
            narrow_field = {1'b1, 16'h7fff};
        end else if (v < V_MIN) begin
            narrow_field = {1'b1, 16'h8000};
        end else begin
            narrow_field = {1'b0, v[15:0]};
        end
    endfunction

    logic          in_vld;
    logic [16:0]   nx, ny, nz;
    entry_t        wr_entry;
    entry_t        head;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [FW-1:0] fill_q, fill_d;
    logic [FW-1:0] credit_q, credit_d;
    logic          credit_avail_q, credit_avail_d;
    logic          err_q, err_d;

    logic          empty, full, push, pop, overflow, bad_issue;

    // Narrow the incoming fields into a FIFO entry.
    always_comb begin
        in_vld        = cordic_out_i[54];
        nx            = narrow_field(cordic_out_i[53:36]);
        ny            = narrow_field(cordic_out_i[35:18]);
        nz            = narrow_field(cordic_out_i[17:0]);
        wr_entry.data = {nx[15:0], ny[15:0], nz[15:0]};
        wr_entry.sat  = {nx[16], ny[16], nz[16]};
    end

    // FIFO control, credit accounting and sticky error next-state.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop       = !empty && res_rdy_i;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push      = in_vld && (!full || pop);
        overflow  = in_vld && full && !pop;
        bad_issue = issue_i && (credit_q == '0);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        fill_d = fill_q;
        if (push && !pop)      fill_d = fill_q + FW'(1);
        else if (pop && !push) fill_d = fill_q - FW'(1);

        credit_d = credit_q;
        if (issue_i && !pop) begin
            if (credit_q != '0) credit_d = credit_q - FW'(1);
        end else if (pop && !issue_i) begin
            if (credit_q != FW'(DEPTH)) credit_d = credit_q + FW'(1);
        end
        credit_avail_d = (credit_d != '0);

        err_d = err_q | overflow | bad_issue;
    end

    // Storage next-state: only the written slot changes.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fill_q         <= '0;
            credit_q       <= FW'(DEPTH);
            credit_avail_q <= 1'b1;
            err_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            fill_q         <= fill_d;
            credit_q       <= credit_d;
            credit_avail_q <= credit_avail_d;
            err_q          <= err_d;
        end
    end

    // Storage has no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head is read from registered storage, so a push shows up one cycle later.
    always_comb begin
        head           = mem_q[rd_ptr_q[AW-1:0]];
        res_vld_o      = !empty;
        res_data_o     = empty ? '0 : head.data;
        res_sat_o      = empty ? '0 : head.sat;
        fill_o         = fill_q;
        credit_avail_o = credit_avail_q;
        err_o          = err_q;
    end

endmodule

// File: tb/tb_cordic_result_collector.sv
// Testbench for cordic_result_collector: directed steps plus a randomized
// back-pressure phase, checked against a queue-based reference model.
// Two instances share stimulus: FRAC_SHIFT=2 (default) and FRAC_SHIFT=1.
module tb_cordic_result_collector;

    localparam int DEPTH = 8;
    localparam int FW    = $clog2(DEPTH+1);

`ifdef CORDIC_RES_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [54:0]   cordic_out_i = '0;
    logic          issue_i = 1'b0;
    logic          res_rdy_i = 1'b0;

    logic          credit_avail_o, res_vld_o, err_o;
    logic [47:0]   res_data_o;
    logic [2:0]    res_sat_o;
    logic [FW-1:0] fill_o;

    logic          credit_avail_1, res_vld_1, err_1;
    logic [47:0]   res_data_1;
    logic [2:0]    res_sat_1;
    logic [FW-1:0] fill_1;

    always #5 clk = ~clk;

    cordic_result_collector #(.DEPTH(DEPTH), .FRAC_SHIFT(2)) u_dut (
        .clk(clk), .rst(rst), .cordic_out_i(cordic_out_i), .issue_i(issue_i),
        .credit_avail_o(credit_avail_o), .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i),
        .res_data_o(res_data_o), .res_sat_o(res_sat_o), .fill_o(fill_o), .err_o(err_o)
    );

    cordic_result_collector #(.DEPTH(DEPTH), .FRAC_SHIFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .cordic_out_i(cordic_out_i), .issue_i(issue_i),
        .credit_avail_o(credit_avail_1), .res_vld_o(res_vld_1), .res_rdy_i(res_rdy_i),
        .res_data_o(res_data_1), .res_sat_o(res_sat_1), .fill_o(fill_1), .err_o(err_1)
    );

    typedef struct {
        int       x0, y0, z0;
        bit [2:0] s0;
        int       x1, y1, z1;
        bit [2:0] s1;
    } exp_t;

    exp_t mq[$];
    int   m_cred;
    bit   m_err;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Narrowing rule in plain integer arithmetic: floor((f + rnd) / 2^fs), clamped.
    function automatic void nar(input int f, input int fs, output int v, output bit s);
        int d, t, r;
        d = 1 << fs;
        t = f + ((ROUND && fs > 0) ? d / 2 : 0);
        r = ((t % d) + d) % d;
        v = (t - r) / d;
        s = 1'b0;
        if (v > 32767) begin
            v = 32767;  s = 1'b1;
        end else if (v < -32768) begin
            v = -32768; s = 1'b1;
        end
    endfunction

    function automatic exp_t make_entry(input int x, input int y, input int z);
        exp_t e;
        nar(x, 2, e.x0, e.s0[2]); nar(y, 2, e.y0, e.s0[1]); nar(z, 2, e.z0, e.s0[0]);
        nar(x, 1, e.x1, e.s1[2]); nar(y, 1, e.y1, e.s1[1]); nar(z, 1, e.z1, e.s1[0]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        chk("res_vld", res_vld_o, mq.size() != 0);
        chk("fill", fill_o, 64'(mq.size()));
        chk("err", err_o, m_err);
        chk("credit_avail", credit_avail_o, m_cred != 0);
        chk("res_vld_fs1", res_vld_1, mq.size() != 0);
        chk("fill_fs1", fill_1, 64'(mq.size()));
        chk("err_fs1", err_1, m_err);
        chk("credit_avail_fs1", credit_avail_1, m_cred != 0);
        if (mq.size() != 0) begin
            e = mq[0];
            chk("head_data", res_data_o, {16'(e.x0), 16'(e.y0), 16'(e.z0)});
            chk("head_sat", res_sat_o, e.s0);
            chk("head_data_fs1", res_data_1, {16'(e.x1), 16'(e.y1), 16'(e.z1)});
            chk("head_sat_fs1", res_sat_1, e.s1);
        end
    endtask

    // One clock cycle of stimulus with the model stepped alongside.
    task automatic cyc(input bit vld, input int x, input int y, input int z,
                       input bit iss, input bit rdy);
        bit pop, push;
        cordic_out_i = {vld, 18'(x), 18'(y), 18'(z)};
        issue_i      = iss;
        res_rdy_i    = rdy;
        pop  = (mq.size() != 0) && rdy;
        push = vld && ((mq.size() < DEPTH) || pop);
        @(posedge clk); #1;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(make_entry(x, y, z));
        if (vld && !push) m_err = 1'b1;
        if (iss && m_cred == 0)            m_err = 1'b1;
        else if (iss && !pop)              m_cred--;
        else if (pop && !iss && m_cred < DEPTH) m_cred++;
        cordic_out_i = '0;
        issue_i      = 1'b0;
        res_rdy_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cordic_out_i = '0;
        issue_i = 1'b0;
        res_rdy_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        m_cred = DEPTH;
        m_err  = 1'b0;
    endtask

    initial begin
        int  pushed, cycles, rx, ry, rz;
        bit  rv, ri, rr;

        // Reset state
        do_reset();
        chk("rst_vld", res_vld_o, 1'b0);
        chk("rst_data", res_data_o, 48'h0);
        chk("rst_sat", res_sat_o, 3'b000);
        chk("rst_fill", fill_o, 0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_credit", credit_avail_o, 1'b1);

        // Single result; no fall-through in the push cycle
        cordic_out_i = {1'b1, 18'(1000), 18'(-1000), 18'(1002)};
        #1;
        chk("no_fallthrough", res_vld_o, 1'b0);
        cyc(1'b1, 1000, -1000, 1002, 1'b0, 1'b0);
        check_all();
        chk("single_vld", res_vld_o, 1'b1);
        chk("single_x", res_data_o[47:32], 16'd250);
        chk("single_y", res_data_o[31:16], 16'hff06);
        chk("single_z", res_data_o[15:0], ROUND ? 16'd251 : 16'd250);
        chk("single_sat", res_sat_o, 3'b000);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        check_all();

        // Saturation corners
        cyc(1'b1, 131071, -131072, 0, 1'b0, 1'b0);
        check_all();
        chk("sat_x", res_data_o[47:32], 16'h7fff);
        chk("sat_y", res_data_o[31:16], 16'h8000);
        chk("sat_flags", res_sat_o, ROUND ? 3'b100 : 3'b000);
        chk("sat_x_fs1", res_data_1[47:32], 16'h7fff);
        chk("sat_y_fs1", res_data_1[31:16], 16'h8000);
        chk("sat_flags_fs1", res_sat_1, 3'b110);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        check_all();

        // Credits: exhaust, issue without credit, recover via pop
        do_reset();
        cyc(1'b1, 4, 8, 12, 1'b0, 1'b0);
        check_all();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
            check_all();
        end
        chk("credit_exhausted", credit_avail_o, 1'b0);
        chk("credit_no_err", err_o, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b1, 1'b0);
        check_all();
        chk("issue_no_credit_err", err_o, 1'b1);
        chk("issue_no_credit_stays0", credit_avail_o, 1'b0);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
        check_all();
        chk("credit_after_pop", credit_avail_o, 1'b1);

        // Overflow: push+pop when full is accepted, lone push when full is dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, i * 40, -i * 40, i, 1'b0, 1'b0);
            check_all();
        end
        chk("full_fill", fill_o, 8);
        cyc(1'b1, 2000, 2004, 2008, 1'b0, 1'b1);
        check_all();
        chk("full_pushpop_fill", fill_o, 8);
        chk("full_pushpop_err", err_o, 1'b0);
        cyc(1'b1, 7777, 7777, 7777, 1'b0, 1'b0);
        check_all();
        chk("overflow_fill", fill_o, 8);
        chk("overflow_err", err_o, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
            check_all();
        end
        chk("overflow_drained", res_vld_o, 1'b0);

        // Random back-pressure over 32 accepted pushes
        do_reset();
        pushed = 0;
        cycles = 0;
        while (pushed < 32 && cycles < 1000) begin
            rv = (mq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            ri = (m_cred != 0) && ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 1) == 1);
            rx = int'($urandom_range(0, 262143)) - 131072;
            ry = int'($urandom_range(0, 262143)) - 131072;
            rz = int'($urandom_range(0, 262143)) - 131072;
            if (rv) pushed++;
            cyc(rv, rx, ry, rz, ri, rr);
            check_all();
            cycles++;
        end
        chk("rand_pushes", 64'(pushed), 64'd32);
        for (int i = 0; i < DEPTH + 2; i++) begin
            cyc(1'b0, 0, 0, 0, 1'b0, 1'b1);
            check_all();
        end
        chk("rand_drained", res_vld_o, 1'b0);
        chk("rand_err", err_o, 1'b0);

        // Reset mid-operation with five entries held
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, i * 100, i * 200, i * 300, 1'b1, 1'b0);
            check_all();
        end
        chk("pre_reset_fill", fill_o, 5);
        do_reset();
        check_all();
        chk("post_reset_fill", fill_o, 0);
        chk("post_reset_vld", res_vld_o, 1'b0);
        chk("post_reset_credit", credit_avail_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
